// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: drives the data-memory req/ack port, extracts and extends load
// data, owns the MEM->WB pipeline register and supplies forwarding data and a stall.
module rv32i_mem_stage #(
    parameter logic [31:0] NOP_IW   = 32'h00000013,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misalign;
    logic        mem_go;
    logic        done;
    logic        abort;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode, alignment check and lane steering for the current instruction
    always_comb begin
        is_load    = (iw_in[6:0] == OPC_LOAD);
        is_store   = (iw_in[6:0] == OPC_STORE);
        is_mem     = is_load | is_store;
        misalign   = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = rs2_in;
        case (iw_in[13:12])
            2'b00: begin
                lane_be    = 4'b0001 << alu_in[1:0];
                lane_wdata = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                lane_be    = alu_in[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{rs2_in[15:0]}};
                misalign   = alu_in[0];
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = rs2_in;
                misalign   = |alu_in[1:0];
            end
        endcase
        misalign = misalign & is_mem;
        mem_go   = is_mem & ~misalign;
    end

    // Load byte/halfword selection and extension
    always_comb begin
        ld_byte = dm_rdata[{alu_in[1:0], 3'b000} +: 8];
        ld_half = alu_in[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (iw_in[14:12])
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    assign dm_req    = ~reset & mem_go;
    assign dm_we     = dm_req & is_store;
    assign dm_addr   = {alu_in[31:2], 2'b00};
    assign dm_be     = dm_req ? lane_be : 4'b0000;
    assign dm_wdata  = dm_we ? lane_wdata : 32'h0;
    assign done      = dm_req & dm_ack;
    assign abort     = (state_q == BUSY) & dm_req & ~dm_ack
                     & (cnt_q == CNT_W'(MAX_WAIT - 1));
    assign stall_out = dm_req & ~dm_ack & ~abort;

    assign df_mem_enable = wb_en_out;
    assign df_mem_reg    = wb_reg_out;
    assign df_mem_data   = alu_out;

    // Request FSM, wait counter and MEM->WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_en_out    <= 1'b0;
            wb_reg_out   <= 5'd0;
            pc_out       <= 32'h0;
            iw_out       <= NOP_IW;
            alu_out      <= 32'h0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall_out) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (stall_out) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (stall_out) begin
                wb_en_out    <= 1'b0;
                wb_reg_out   <= 5'd0;
                pc_out       <= 32'h0;
                iw_out       <= NOP_IW;
                alu_out      <= 32'h0;
                misalign_err <= 1'b0;
                bus_err      <= 1'b0;
            end else begin
                wb_en_out    <= wb_en_in & ~is_store & ~misalign & ~abort;
                wb_reg_out   <= wb_reg_in;
                pc_out       <= pc_in;
                iw_out       <= iw_in;
                alu_out      <= (is_load & done) ? ld_data : alu_in;
                misalign_err <= misalign;
                bus_err      <= abort;
            end
        end
    end

endmodule
